// File: rtl/sar_search.sv
// Successive-approximation search: finds a target by driving probe into an external comparator and reading lt back.
// Latency: bits+1 cycles from the edge that accepts start to the single-cycle done pulse.
// Backpressure: none; start is ignored while busy. Optional abort input when SAR_SEARCH_ABORT_EN is defined.
module sar_search #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            lt,
`ifdef SAR_SEARCH_ABORT_EN
    input  logic            abort,
`endif
    output logic [bits-1:0] probe,
    output logic            busy,
    output logic            done,
    output logic [bits-1:0] result
);

    // Bit index needs at least one bit even for a single-bit search.
    localparam int IW = (bits > 1) ? $clog2(bits) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [bits-1:0]   acc;
    logic [bits-1:0]   acc_nxt;
    logic [bits-1:0]   result_nxt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     idx_nxt;
    logic [bits-1:0]   bit_mask;
    logic [bits-1:0]   acc_with_bit;
    logic              abort_req;

`ifdef SAR_SEARCH_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // One-hot mask of the bit currently being decided, and the trial value it produces.
    always_comb begin
        bit_mask     = bits'(1) << idx;
        acc_with_bit = acc | bit_mask;
    end

    // Next-state, datapath updates and outputs; lt and abort only matter while searching.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        idx_nxt    = idx;
        result_nxt = result;
        probe      = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SEARCH;
                    acc_nxt   = '0;
                    idx_nxt   = IW'(bits - 1);
                end
            end
            SEARCH: begin
                busy  = 1'b1;
                probe = acc_with_bit;
                if (abort_req) begin
                    // Abandon the search; result keeps the previous completed value.
                    state_nxt = IDLE;
                end else begin
                    // Target is not below the trial value, so this bit belongs in the answer.
                    if (!lt) begin
                        acc_nxt = acc_with_bit;
                    end
                    if (idx == '0) begin
                        state_nxt  = DONE;
                        result_nxt = lt ? acc : acc_with_bit;
                    end else begin
                        idx_nxt = idx - IW'(1);
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, accumulator, bit index and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= IW'(bits - 1);
            result <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            idx    <= idx_nxt;
            result <= result_nxt;
        end
    end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter bits, default 8: width of probe, result and internal accumulator.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 lt  input  1  compare response, 1 when target < probe; driven combinationally by an external CMP with a=target, b=probe.
REQ-006 probe  output  bits  candidate value presented to the comparator's b input.
REQ-007 busy  output  1  high in SEARCH and DONE states.
REQ-008 done  output  1  one-cycle pulse when result is updated.
REQ-009 result  output  bits  last completed search value; registered.

Function
REQ-010 States SHALL be IDLE, SEARCH and DONE; encoding is free.
REQ-011 IDLE with start=1 SHALL go to SEARCH, clear accumulator acc to 0 and set bit index i to bits-1; start=0 SHALL stay in IDLE.
REQ-012 In SEARCH, probe SHALL equal acc with bit i set; in IDLE and DONE probe SHALL be 0.
REQ-013 In each SEARCH cycle, lt=0 SHALL set acc[i] and lt=1 SHALL leave acc[i] clear at the next edge.
REQ-014 SEARCH SHALL last exactly bits cycles (i = bits-1 down to 0), then go to DONE.
REQ-015 At the SEARCH to DONE edge, result SHALL load the final acc.
REQ-016 In DONE, done SHALL be 1; DONE SHALL last one cycle and then go to IDLE.
REQ-017 With start accepted on edge N, done SHALL be high in the cycle after edge N+bits; total latency is bits+1 cycles.
REQ-018 start SHALL be ignored in SEARCH and DONE, with no restart and no queuing.
REQ-019 result SHALL hold its value from one completion to the next; accepting start SHALL NOT change result.
REQ-020 Targets 0 and 2^bits-1 SHALL resolve correctly with no wrap-around; acc never exceeds bits width.
REQ-021 lt SHALL be used only in SEARCH cycles; its value in other states SHALL have no effect.

Reset
REQ-022 rst=1 SHALL immediately force IDLE and set acc=0, i=bits-1, result=0, probe=0, busy=0, done=0.
REQ-023 rst asserted during SEARCH or DONE SHALL abort the search, with no done pulse and result=0.
REQ-024 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Configuration
REQ-025 Macro SAR_SEARCH_ABORT_EN SHALL control an abort feature.
REQ-026 With the macro defined, an extra input abort (1 bit) SHALL exist; abort=1 in SEARCH SHALL return to IDLE at the next edge with no done pulse and result unchanged; abort SHALL be ignored in IDLE and DONE; if start and abort are both high in IDLE, start SHALL be accepted.
REQ-027 Without the macro, port abort SHALL be absent and behaviour SHALL be exactly as in REQ-010 to REQ-024.

Verification
REQ-028 bits=8, target 0xA5, start pulse -> probe sequence 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; done high 9 cycles after the start edge; result=0xA5.
REQ-029 Target 0x00 -> all 8 probes give lt=1, result=0x00; target 0xFF -> all probes give lt=0, result=0xFF, last probe 0xFF.
REQ-030 Target 0x3C search; start held high throughout SEARCH -> no restart, single done, result=0x3C; start still high in the cycle after DONE -> new search begins.
REQ-031 rst asserted in the 4th SEARCH cycle -> outputs zero asynchronously, no done pulse; a new search for 0x11 then yields result=0x11.
REQ-032 With SAR_SEARCH_ABORT_EN, complete search for 0x42, then search for 0x99 with abort in the 3rd SEARCH cycle -> IDLE next cycle, no done pulse, result remains 0x42.
